// File: rtl/gpio_sync_debounce_pkg.sv
// gpio_sync_debounce_pkg
//   Shared types and helpers for the GPIO debouncer:
//   - db_state_e : debounce FSM states
//   - EDGE_*     : edge_sel encodings for IRQ source selection
//   - edge_event : maps the rise/fall strobes and edge_sel to an IRQ event
package gpio_sync_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } db_state_e;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic logic edge_event(input logic [1:0] sel,
                                      input logic       rise,
                                      input logic       fall);
    logic want_rise;
    logic want_fall;
    want_rise = (sel == EDGE_RISE) || (sel == EDGE_BOTH);
    want_fall = (sel == EDGE_FALL) || (sel == EDGE_BOTH);
    return (rise && want_rise) || (fall && want_fall);
  endfunction

endpackage

// File: rtl/debounce_irq_latch.sv
// debounce_irq_latch
//   Sticky interrupt request with overrun detection. Shared by several
//   peripheral interrupt sources.
//   Ports:
//     clk, nreset   clock, asynchronous active-low reset
//     event_i       one-cycle interrupt event
//     irq_clr       one-cycle clear of irq_o and overrun_o
//     irq_o         sticky request (set wins over clear)
//     overrun_o     event seen while irq_o already pending and not being cleared
module debounce_irq_latch (
  input  logic clk,
  input  logic nreset,
  input  logic event_i,
  input  logic irq_clr,
  output logic irq_o,
  output logic overrun_o
);

  logic irq_q, irq_d;
  logic ovr_q, ovr_d;

  always_comb begin
    irq_d = event_i | (irq_q & ~irq_clr);
    ovr_d = ovr_q;
    // A clear in the same cycle as a new event means software has serviced
    // the old request, so the new one is not an overrun.
    if (irq_clr) begin
      ovr_d = 1'b0;
    end else if (event_i && irq_q) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      irq_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
      ovr_q <= ovr_d;
    end
  end

  assign irq_o     = irq_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/gpio_sync_debounce.sv
// gpio_sync_debounce
//   Debouncer and edge qualifier for an already-synchronized GPIO level.
//   A new level is committed after L = max(db_len,1) consecutive samples.
//   Ports:
//     clk, nreset   clock, asynchronous active-low reset
//     sync_i        synchronized input level
//     en            block enable (0: hold level, drop any candidate)
//     db_len        required stable cycles
//     edge_sel      IRQ source select (none/rise/fall/both)
//     irq_clr       clear irq_o / overrun_o
//     level_o       debounced level
//     rise_o/fall_o one-cycle commit strobes
//     irq_o         sticky interrupt request
//     overrun_o     sticky overrun flag
//   state_q holds the FSM state for observation by checkers.
module gpio_sync_debounce
  import gpio_sync_debounce_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             sync_i,
  input  logic             en,
  input  logic [CNT_W-1:0] db_len,
  input  logic [1:0]       edge_sel,
  input  logic             irq_clr,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             irq_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             irq_event;

  assign len_eff = (db_len == '0) ? ONE : db_len;
  // Saturating increment; commit normally happens first since L <= max.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (!en) begin
      state_d = level_q ? STABLE_HI : STABLE_LO;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        STABLE_LO: begin
          if (sync_i) begin
            if (len_eff == ONE) begin
              state_d = STABLE_HI;
              level_d = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = QUAL_HI;
              cnt_d   = ONE;
            end
          end
        end
        QUAL_HI: begin
          if (!sync_i) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_inc >= len_eff) begin
            // >= so that shrinking db_len mid-qualification commits at once.
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        STABLE_HI: begin
          if (!sync_i) begin
            if (len_eff == ONE) begin
              state_d = STABLE_LO;
              level_d = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = QUAL_LO;
              cnt_d   = ONE;
            end
          end
        end
        QUAL_LO: begin
          if (sync_i) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_inc >= len_eff) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Event taken from the registered strobes, so irq_o follows one cycle later.
  assign irq_event = edge_event(edge_sel, rise_q, fall_q);

  debounce_irq_latch u_irq_latch (
    .clk       (clk),
    .nreset    (nreset),
    .event_i   (irq_event),
    .irq_clr   (irq_clr),
    .irq_o     (irq_o),
    .overrun_o (overrun_o)
  );

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: tb/tb_gpio_sync_debounce.sv
// tb_gpio_sync_debounce
//   Inputs change on the falling edge. A reference model updates on every
//   rising edge and queues the expected {level,rise,fall,irq,overrun}; a
//   monitor samples the DUT 1ns after the rising edge and compares.
module tb_gpio_sync_debounce;

  localparam int CNT_W = 8;

  logic             clk;
  logic             nreset;
  logic             sync_i;
  logic             en;
  logic [CNT_W-1:0] db_len;
  logic [1:0]       edge_sel;
  logic             irq_clr;
  logic             level_o, rise_o, fall_o, irq_o, overrun_o;

  int tests = 0;
  int fails = 0;

  logic [4:0] exp_q[$];

  gpio_sync_debounce #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .sync_i    (sync_i),
    .en        (en),
    .db_len    (db_len),
    .edge_sel  (edge_sel),
    .irq_clr   (irq_clr),
    .level_o   (level_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .irq_o     (irq_o),
    .overrun_o (overrun_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The output level flips once the input has disagreed with it for L
  // consecutive enabled samples; anything else resets the run length.
  logic m_level, m_rise, m_fall, m_irq, m_ovr;
  int   m_run;

  always @(posedge clk) begin
    int  len;
    logic ev, n_irq, n_ovr;
    if (!nreset) begin
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_irq = 1'b0; m_ovr = 1'b0; m_run = 0;
    end else begin
      len = (db_len == 0) ? 1 : int'(db_len);
      ev = (m_rise && edge_sel[0]) || (m_fall && edge_sel[1]);
      n_irq = ev || (m_irq && !irq_clr);
      if (irq_clr) n_ovr = 1'b0;
      else if (ev && m_irq) n_ovr = 1'b1;
      else n_ovr = m_ovr;
      m_irq = n_irq;
      m_ovr = n_ovr;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (en && (sync_i != m_level)) begin
        m_run = m_run + 1;
        if (m_run >= len) begin
          m_level = sync_i;
          if (sync_i) m_rise = 1'b1;
          else m_fall = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    exp_q.push_back({m_level, m_rise, m_fall, m_irq, m_ovr});
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got {lvl,rise,fall,irq,ovr}=%b expected %b",
               name, $time, act, exp);
    end
  endtask

  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("queue_empty", {level_o, rise_o, fall_o, irq_o, overrun_o}, 5'bxxxxx);
      end else begin
        e = exp_q.pop_front();
        check("cycle", {level_o, rise_o, fall_o, irq_o, overrun_o}, e);
      end
    end
  end

  // ---------------- driver ----------------
  int clr_rate = 0;

  // Drive sync_i=v for n cycles; irq_clr pulses on iteration clr_at and,
  // when clr_rate>0, randomly with probability 1/clr_rate.
  task automatic hold(input logic v, input int n, input int clr_at = -1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sync_i  = v;
      irq_clr = (i == clr_at) ||
                ((clr_rate > 0) && ($urandom_range(clr_rate - 1, 0) == 0));
    end
  endtask

  initial begin
    int cycles;
    int len;
    nreset   = 1'b0;
    sync_i   = 1'b0;
    en       = 1'b1;
    db_len   = 8'd4;
    edge_sel = 2'b01;
    irq_clr  = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // L=4, rise only
    hold(1'b0, 3);
    hold(1'b1, 3);          // too short: filtered
    hold(1'b0, 5);
    hold(1'b1, 8);          // commit after 4th sample, irq next cycle
    hold(1'b0, 6);          // fall not selected
    hold(1'b1, 6);          // second rise -> overrun
    edge_sel = 2'b11;
    hold(1'b0, 7, 4);       // clear coincident with fall event: irq=1, ovr=0
    hold(1'b0, 2, 0);       // plain clear

    // L=1, both edges, toggle every 2 cycles
    db_len = '0;
    for (int k = 0; k < 8; k++) hold(k[0] ? 1'b0 : 1'b1, 2);
    hold(1'b0, 3);

    // reset in QUAL_HI with cnt=2, irq pending
    db_len = 8'd4;
    hold(1'b1, 2);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("async_reset", {level_o, rise_o, fall_o, irq_o, overrun_o}, 5'b00000);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    hold(1'b1, 8);

    // disabled while input toggles, then re-enable with opposite level
    en = 1'b0;
    for (int k = 0; k < 20; k++) hold(k[0], 1);
    en = 1'b1;
    hold(1'b0, 8);

    // randomized phase
    clr_rate = 6;
    cycles = 0;
    while (cycles < 3000) begin
      if ($urandom_range(3, 0) == 0) db_len = CNT_W'($urandom_range(6, 0));
      if ($urandom_range(7, 0) == 0) edge_sel = 2'($urandom_range(3, 0));
      en  = ($urandom_range(15, 0) != 0);
      len = $urandom_range(8, 1);
      hold(1'($urandom_range(1, 0)), len);
      cycles += len;
    end
    clr_rate = 0;
    hold(1'b0, 4);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
